// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control:
// state encodings, opcodes and datapath select constants.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memtoreg;
    logic       regdst;
    logic       reg_write;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ) ||
           (op == OP_J)     || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Moore output decoder: state (plus mem_ready in FETCH) to
// datapath controls, with all side effects gated off in reset.
module mc_ctrl_outputs
  import mc_ctrl_pkg::*;
(
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       op_legal,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.alusrcb  = SRCB_FOUR;
        c.aluop    = ALUOP_ADD;
        c.pcsource = PCSRC_ALU;
        c.ir_write = mem_ready;
        c.pc_write = mem_ready;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_BOFS;
        c.aluop   = ALUOP_ADD;
        c.illegal = ~op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg  = 1'b1;
        c.reg_write = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst    = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca       = 1'b1;
        c.alusrcb       = SRCB_REG;
        c.aluop         = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pcsource      = PCSRC_OUT;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pcsource = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    if (!rst_n) begin
      c.pc_write      = 1'b0;
      c.pc_write_cond = 1'b0;
      c.mem_read      = 1'b0;
      c.mem_write     = 1'b0;
      c.ir_write      = 1'b0;
      c.reg_write     = 1'b0;
      c.illegal       = 1'b0;
    end
  end

  assign PCWrite     = c.pc_write;
  assign PCWriteCond = c.pc_write_cond;
  assign IorD        = c.iord;
  assign MemRead     = c.mem_read;
  assign MemWrite    = c.mem_write;
  assign IRWrite     = c.ir_write;
  assign MemtoReg    = c.memtoreg;
  assign RegDst      = c.regdst;
  assign RegWrite    = c.reg_write;
  assign ALUSrcA     = c.alusrca;
  assign ALUSrcB     = c.alusrcb;
  assign ALUOp       = c.aluop;
  assign PCSource    = c.pcsource;
  assign illegal_op  = c.illegal;

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register and next-state
// logic; output decoding lives in mc_ctrl_outputs.
module mc_main_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t cur, nxt, dec_nxt;
  logic   is_mem, is_r, is_beq, is_j, is_addi;

  assign is_mem  = (Op == OP_LW) || (Op == OP_SW);
  assign is_r    = (Op == OP_RTYPE);
  assign is_beq  = (Op == OP_BEQ);
  assign is_j    = (Op == OP_J);
  assign is_addi = (Op == OP_ADDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    dec_nxt = S_FETCH;
    unique case (1'b1)
      is_mem:  dec_nxt = S_MEMADR;
      is_r:    dec_nxt = S_EXEC;
      is_beq:  dec_nxt = S_BRANCH;
      is_j:    dec_nxt = S_JUMP;
      is_addi: dec_nxt = S_ADDIEX;
      default: dec_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = dec_nxt;
      S_MEMADR: nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  assign state = cur;

  mc_ctrl_outputs u_out (
    .rst_n       (rst_n),
    .state       (cur),
    .mem_ready   (mem_ready),
    .op_legal    (op_known(Op)),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op)
  );

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: directed per-cycle vectors
// are queued by the driver and checked by a negedge monitor.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       illegal_op;
  logic [3:0] state;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {PCW,PCWC,IorD,MR,MW,IRW,M2R,RD,RW,SA,SB[2],AOP[2],PCS[2],ILL}
  localparam logic [16:0] RST  = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] F1   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] F0   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] DECI = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] MADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] EXE  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] AWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] AEX  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] IWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BQ = 6'b000100;
  localparam logic [5:0] JJ = 6'b000010, AI = 6'b001000;
  localparam logic [5:0] XX = 6'b111111;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [16:0] c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   nstep = 0;
  logic watch = 1'b0;
  logic rw_seen = 1'b0;

  wire [16:0] act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                     IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                     ALUSrcB, ALUOp, PCSource, illegal_op};

  always @(RegWrite or watch)
    if (watch && RegWrite !== 1'b0) rw_seen = 1'b1;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (state !== e.st) begin
        bad++;
        $display("FAIL state step%0d: got %0d want %0d",
                 e.id, state, e.st);
      end
      total++;
      if (act !== e.c) begin
        bad++;
        $display("FAIL ctrl step%0d: got %b want %b",
                 e.id, act, e.c);
      end
    end
  end

  task automatic step(input logic r, input logic mr,
                      input logic [5:0] op, input logic [3:0] st,
                      input logic [16:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    mem_ready = mr;
    Op = op;
    e.id = nstep;
    e.st = st;
    e.c = c;
    q.push_back(e);
    nstep++;
  endtask

  initial begin
    // reset held three cycles
    step(0, 1, RT, 0, RST);
    step(0, 1, RT, 0, RST);
    step(0, 1, RT, 0, RST);
    // lw
    step(1, 1, LW, 0, F1);
    step(1, 1, LW, 1, DEC);
    step(1, 1, LW, 2, MADR);
    step(1, 1, LW, 3, MRD);
    step(1, 1, LW, 4, MWB);
    // R-type
    step(1, 1, RT, 0, F1);
    step(1, 1, RT, 1, DEC);
    step(1, 1, RT, 6, EXE);
    step(1, 1, RT, 7, AWB);
    // beq
    step(1, 1, BQ, 0, F1);
    step(1, 1, BQ, 1, DEC);
    step(1, 1, BQ, 8, BR);
    // j
    step(1, 1, JJ, 0, F1);
    step(1, 1, JJ, 1, DEC);
    step(1, 1, JJ, 9, JMP);
    // sw with three wait cycles in MEMWR
    step(1, 1, SW, 0, F1);
    step(1, 1, SW, 1, DEC);
    step(1, 1, SW, 2, MADR);
    step(1, 0, SW, 5, MWR);
    step(1, 0, SW, 5, MWR);
    step(1, 0, SW, 5, MWR);
    step(1, 1, SW, 5, MWR);
    // addi with two wait cycles in FETCH
    step(1, 0, AI, 0, F0);
    step(1, 0, AI, 0, F0);
    step(1, 1, AI, 0, F1);
    step(1, 1, AI, 1, DEC);
    step(1, 1, AI, 10, AEX);
    step(1, 1, AI, 11, IWB);
    // illegal opcode
    step(1, 1, XX, 0, F1);
    step(1, 1, XX, 1, DECI);
    // addi interrupted by reset in ADDIEX
    step(1, 1, AI, 0, F1);
    step(1, 1, AI, 1, DEC);
    step(1, 1, AI, 10, AEX);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    watch = 1'b1;
    #1;
    total++;
    if (state !== 4'd0 || RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: got st=%0d rw=%b want st=0 rw=0",
               state, RegWrite);
    end
    step(0, 1, AI, 0, RST);
    step(1, 1, AI, 0, F1);
    step(1, 1, AI, 1, DEC);
    step(1, 1, LW, 10, AEX);
    watch = 1'b0;
    total++;
    if (rw_seen !== 1'b0) begin
      bad++;
      $display("FAIL rw_after_rst: got seen=%b want 0", rw_seen);
    end
    // lw with one wait cycle in MEMRD
    step(1, 1, RT, 11, IWB);
    step(1, 1, LW, 0, F1);
    step(1, 1, LW, 1, DEC);
    step(1, 0, LW, 2, MADR);
    step(1, 0, LW, 3, MRD);
    step(1, 1, LW, 3, MRD);
    step(1, 1, LW, 4, MWB);
    step(1, 1, LW, 0, F1);
    begin
      int n;
      n = 0;
      while (q.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multicycle MIPS main control unit. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. From the 6-bit opcode it drives every datapath enable and mux select, plus the 2-bit ALUOp that the ALU control decoder expands with Funct into the 4-bit ALUControl. The block sits between the instruction register opcode field and the multicycle datapath. Memory accesses wait on a ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- Op  in  6  opcode, IR[31:26].
- mem_ready  in  1  memory has completed the current read or write.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU Zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  ALU operation class: 00 = add, 01 = subtract, 10 = use Funct.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  unsupported opcode seen in DECODE.
- state  out  4  current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Outputs are Moore outputs decoded from the state. Any output not listed for a state is 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - lw or sw → MEMADR.
  - R-type → EXEC.
  - beq → BRANCH.
  - j → JUMP.
  - addi → ADDIEX.
  - anything else → FETCH, with illegal_op=1 for this cycle.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD (3): MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1. Next is FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next is FETCH.
- JUMP (9): PCWrite=1, PCSource=10. Next is FETCH.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
- ADDIWB (11): RegDst=0, MemtoReg=0, RegWrite=1. Next is FETCH.
- Encodings 12–15 are unreachable. If ever entered, the next state is FETCH.

## Timing
- The state register updates on the rising clk edge. Outputs are combinational from state; FETCH also depends on mem_ready.
- Reset:
  - rst_n low forces state=FETCH immediately (asynchronous).
  - While rst_n is low, every write enable, MemRead and illegal_op are forced to 0.
  - Reset mid-instruction abandons the instruction. No partial writes occur after assertion.
- Cycles per instruction with mem_ready tied to 1 (FETCH entry to next FETCH entry): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Request signals stay asserted and stable while waiting.
- mem_ready is ignored in every other state.
- illegal_op is high for exactly one cycle per illegal instruction.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state encodings (4-bit constants 0–11);
  - the opcode constants;
  - the ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
- The ALU control decoder imports the same ALUOp constants.
- One sub-module, mc_ctrl_outputs: a purely combinational decoder from state, mem_ready and rst_n to all outputs.
- The top level holds only the state register and the next-state logic.

## Test plan
- Reset with rst_n=0 for 3 cycles, mem_ready=1 → state=0, IRWrite=0, PCWrite=0, MemRead=0. After release, the first FETCH cycle has MemRead=1, IRWrite=1, ALUSrcB=01.
- Op=100011 (lw), mem_ready=1 → states 0,1,2,3,4,0. ALUOp=00 in MEMADR. RegWrite=1 with MemtoReg=1 only in state 4.
- Op=000000 (R-type) → states 0,1,6,7,0. ALUOp=10 only in state 6. RegDst=1 and RegWrite=1 in state 7.
- Op=000100 (beq) → states 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8. Op=000010 (j) → state 9 with PCWrite=1, PCSource=10.
- Op=101011 (sw) with mem_ready low for 3 cycles in MEMWR → MemWrite=1, IorD=1 held for 4 cycles, then state 0. mem_ready low for 2 cycles in FETCH → IRWrite=0 for 2 cycles, then a single IRWrite pulse.
- Op=111111 → illegal_op=1 for one cycle in state 1, then state 0. Assert rst_n=0 mid-ADDIEX → state=0 immediately and RegWrite never asserts.
